mem_readout_scanner: RTL and testbench

- Host-side readout engine attached to the processor's parallel memory port.
- Sweeps the processor's externally addressed memory port (parallelAddress in, q out) over a programmed address window.
- Realigns the returned bytes against the fixed read latency and streams them out on a valid/ready byte interface toward the UART/display sink.
- Keeps up to DEPTH reads in flight, so throughput is one byte per cycle when the sink is always ready.

---
 rtl/mem_readout_scanner_pkg.sv | 6 +
 rtl/sync_fifo.sv | 42 ++++
 rtl/mem_readout_scanner.sv | 96 +++++++++
 tb/tb_mem_readout_scanner.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_readout_scanner_pkg.sv
// scan_pkg: shared state encoding and default widths for the memory readout scanner
package scan_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} scan_state_t;
    localparam int SCAN_AW = 24;
    localparam int SCAN_DW = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with a registered head output
module sync_fifo #(
    parameter int DW = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            din,
    input  logic                     pop,
    output logic [DW-1:0]            dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW + 1)'(DEPTH);
    localparam logic [PW:0] ONE = (PW + 1)'(1);
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic do_pop;
    assign do_pop = pop && !empty;
    assign empty = level == '0;
    assign full = level == FULL_LVL;
    always_ff @(posedge clk)
        if (push) mem[wptr] <= din;
    // dout mirrors the head slot so the sink sees a flop, not a memory read path
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
            dout <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            level <= level + (PW + 1)'(push) - (PW + 1)'(do_pop);
            if (push && (empty || (do_pop && level == ONE))) dout <= din;
            else if (do_pop && level > ONE) dout <= mem[rptr + 1'b1];
        end
    end
endmodule

// File: rtl/mem_readout_scanner.sv
// mem_readout_scanner: sweeps the processor memory port over an address window and
// streams the latency-realigned bytes to a valid/ready sink.
module mem_readout_scanner import scan_pkg::*; #(
    parameter int AW = SCAN_AW,
    parameter int DW = SCAN_DW,
    parameter int RD_LAT = 2,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] count,
    output logic [AW-1:0] parallel_address,
    input  logic [DW-1:0] q_in,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW:0] CAP = (LW + 1)'(DEPTH);
    scan_state_t state, state_next;
    logic [AW-1:0] addr, remaining, issued;
    logic [RD_LAT-1:0] tag;
    logic [LW-1:0] inflight, level;
    logic issue, capture, flush, pop, empty, full;
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + LW'(tag[i]);
    end
    // credit counts reads still in the latency pipe plus bytes waiting in the FIFO
    assign issue = state == ISSUE && !abort && issued < remaining &&
                   ({1'b0, inflight} + {1'b0, level}) < CAP;
    assign capture = tag[RD_LAT-1];
    assign flush = abort && state != IDLE;
    assign out_valid = !empty;
    assign pop = out_valid && out_ready;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !abort) state_next = (count == '0) ? DONE : ISSUE;
            ISSUE:   state_next = abort ? IDLE : (issue && issued + 1'b1 == remaining) ? DRAIN : ISSUE;
            DRAIN:   state_next = abort ? IDLE : (inflight == '0 && empty) ? DONE : DRAIN;
            default: state_next = IDLE;
        endcase
    end
    always_comb begin
        busy = state == ISSUE || state == DRAIN;
        done = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            remaining <= '0;
            issued <= '0;
            tag <= '0;
            parallel_address <= '0;
        end else if (flush) begin
            remaining <= '0;
            issued <= '0;
            tag <= '0;
        end else begin
            if (state == IDLE && start && !abort) begin
                addr <= base_addr;
                remaining <= count;
                issued <= '0;
            end
            if (issue) begin
                parallel_address <= addr;
                addr <= addr + 1'b1;
                issued <= issued + 1'b1;
            end
            tag <= (tag << 1) | RD_LAT'(issue);
        end
    end
    always_ff @(posedge clk)
        if (!rst && capture && !pop) assert (!full);
    sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst || flush),
        .push(capture),
        .din(q_in),
        .pop(pop),
        .dout(out_data),
        .empty(empty),
        .full(full),
        .level(level)
    );
endmodule

// File: tb/tb_mem_readout_scanner.sv
// tb_mem_readout_scanner: scoreboard bench for the memory readout scanner
module tb_mem_readout_scanner;
    localparam int AW = 24;
    localparam int DW = 8;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst, start, abort, out_ready, out_valid, busy, done;
    logic [AW-1:0] base_addr, count, parallel_address;
    logic [DW-1:0] q_in, out_data;
    int tests_run = 0;
    int fails = 0;
    int got = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];
    logic stall_pending = 1'b0;
    logic [7:0] stall_data;
    logic [7:0] exp_b;

    mem_readout_scanner #(.AW(AW), .DW(DW), .RD_LAT(2), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_addr(base_addr), .count(count),
        .parallel_address(parallel_address), .q_in(q_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // processor memory: byte = low address byte, seen by the scanner two edges after the address
    always @(posedge clk) q_in <= parallel_address[7:0];

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (out_valid && stall_pending) begin
            tests_run++;
            if (out_data !== stall_data) begin
                fails++;
                $display("FAIL stall_stable: out_data=%h required %h", out_data, stall_data);
            end
        end
        if (out_valid && out_ready) begin
            tests_run++;
            got++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_byte: out_data=%h with empty scoreboard", out_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (out_data !== exp_b) begin
                    fails++;
                    $display("FAIL byte_order: out_data=%h required %h", out_data, exp_b);
                end
            end
        end
        stall_pending = out_valid && !out_ready;
        stall_data = out_data;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic start_scan(input logic [AW-1:0] b, input logic [AW-1:0] c);
        logic [AW-1:0] a;
        for (int i = 0; i < int'(c); i++) begin
            a = b + AW'(i);
            exp_q.push_back(a[7:0]);
        end
        base_addr = b;
        count = c;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int cyc;
        cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i;
                break;
            end
        end
        tests_run++;
        if (cyc < 0) begin
            fails++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        base_addr = '0; count = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tests_run++;
        if (parallel_address !== '0) begin
            fails++;
            $display("FAIL reset_addr: parallel_address=%h required 000000", parallel_address);
        end
        tests_run++;
        if ({out_valid, out_data, busy, done} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%b data=%h busy=%b done=%b required all 0",
                     out_valid, out_data, busy, done);
        end
    endtask

    task automatic test_basic();
        int got0, dc0, first, last, nv, done_at;
        got0 = got; dc0 = done_cnt;
        first = -1; last = -1; nv = 0; done_at = -1;
        start_scan(24'h000010, 24'd5);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                if (first < 0) first = i;
                last = i;
                nv++;
            end
            if (done && done_at < 0) done_at = i;
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (nv != 5 || last - first != 4) begin
            fails++;
            $display("FAIL basic_consecutive: %0d valid cycles spanning %0d required 5 spanning 4", nv, last - first);
        end
        tests_run++;
        if (done_at <= last) begin
            fails++;
            $display("FAIL basic_done_after: done at %0d last byte at %0d", done_at, last);
        end
        tests_run++;
        if (done_cnt - dc0 != 1 || got - got0 != 5) begin
            fails++;
            $display("FAIL basic_counts: done pulses %0d bytes %0d required 1 and 5", done_cnt - dc0, got - got0);
        end
        tests_run++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL basic_idle: busy=%b pending=%0d required 0 and 0", busy, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int issues, pops, max_out, freeze;
        logic seen_done;
        logic [AW-1:0] prev_pa;
        issues = 0; pops = 0; max_out = 0; freeze = 0; seen_done = 1'b0;
        prev_pa = parallel_address;
        start_scan(24'h000100, 24'd12);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1 out_ready = ~out_ready;
            @(negedge clk);
            if (parallel_address != prev_pa) issues++;
            else if (busy && issues > 0 && issues < 12) freeze++;
            prev_pa = parallel_address;
            if (issues - pops > max_out) max_out = issues - pops;
            if (out_valid && out_ready) pops++;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        tests_run++;
        if (!seen_done || issues != 12 || pops != 12) begin
            fails++;
            $display("FAIL bp_counts: done=%b issues=%0d pops=%0d required 1, 12, 12", seen_done, issues, pops);
        end
        tests_run++;
        if (max_out > DEPTH) begin
            fails++;
            $display("FAIL bp_credit: outstanding peaked at %0d required <= %0d", max_out, DEPTH);
        end
        tests_run++;
        if (freeze == 0) begin
            fails++;
            $display("FAIL bp_freeze: address never held while credits exhausted (0 cycles, required >0)");
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL bp_pending: %0d bytes missing required 0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] obs[$];
        logic [AW-1:0] expv [4];
        logic [AW-1:0] prev_pa;
        logic seen_done;
        int got0;
        expv[0] = 24'hFFFFFE; expv[1] = 24'hFFFFFF; expv[2] = 24'h000000; expv[3] = 24'h000001;
        got0 = got; seen_done = 1'b0;
        prev_pa = parallel_address;
        start_scan(24'hFFFFFE, 24'd4);
        for (int i = 0; i < 40 && !seen_done; i++) begin
            @(negedge clk);
            if (parallel_address != prev_pa) obs.push_back(parallel_address);
            prev_pa = parallel_address;
            seen_done = done;
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (obs.size() != 4 || !seen_done) begin
            fails++;
            $display("FAIL wrap_issue_count: %0d addresses done=%b required 4 and 1", obs.size(), seen_done);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (obs[i] !== expv[i]) begin
                    fails++;
                    $display("FAIL wrap_addr%0d: parallel_address=%h required %h", i, obs[i], expv[i]);
                end
            end
        end
        tests_run++;
        if (got - got0 != 4 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL wrap_bytes: %0d bytes pending %0d required 4 and 0", got - got0, exp_q.size());
        end
    endtask

    task automatic test_zero_count();
        int dc0, done_at;
        logic vseen, bseen;
        dc0 = done_cnt; done_at = -1; vseen = 1'b0; bseen = 1'b0;
        start_scan(24'h000055, 24'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) vseen = 1'b1;
            if (busy) bseen = 1'b1;
            if (done && done_at < 0) done_at = i;
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (done_at != 0 || done_cnt - dc0 != 1) begin
            fails++;
            $display("FAIL zero_done: first at %0d pulses %0d required 0 and 1", done_at, done_cnt - dc0);
        end
        tests_run++;
        if (vseen || bseen) begin
            fails++;
            $display("FAIL zero_quiet: out_valid seen=%b busy seen=%b required 0 and 0", vseen, bseen);
        end
    endtask

    task automatic test_abort();
        int got0, dc0;
        logic vseen;
        got0 = got; dc0 = done_cnt; vseen = 1'b0;
        start_scan(24'h000000, 24'd100);
        for (int i = 0; i < 200 && got - got0 < 7; i++) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1 abort = 1'b0;
        tests_run++;
        if (got - got0 != 7) begin
            fails++;
            $display("FAIL abort_point: %0d bytes before abort required 7", got - got0);
        end
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_clear: out_valid=%b busy=%b required 0 and 0", out_valid, busy);
        end
        exp_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) vseen = 1'b1;
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (vseen || done_cnt != dc0) begin
            fails++;
            $display("FAIL abort_quiet: valid seen=%b done pulses %0d required 0 and 0", vseen, done_cnt - dc0);
        end
        got0 = got;
        start_scan(24'h000020, 24'd2);
        wait_done(30, "abort_rescan");
        tests_run++;
        if (got - got0 != 2 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL abort_rescan: %0d bytes pending %0d required 2 and 0", got - got0, exp_q.size());
        end
    endtask

    task automatic test_ignored_start();
        int got0;
        got0 = got;
        start_scan(24'h000300, 24'd6);
        repeat (2) @(posedge clk);
        #1;
        base_addr = 24'h000500;
        count = 24'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL ignored_start_busy: busy=%b required 1", busy);
        end
        wait_done(60, "ignored_start");
        tests_run++;
        if (got - got0 != 6 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL ignored_start_bytes: %0d bytes pending %0d required 6 and 0", got - got0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int got0;
        start_scan(24'h000040, 24'd50);
        repeat (6) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_busy: busy=%b required 1", busy);
        end
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        tests_run++;
        if (parallel_address !== '0 || {out_valid, out_data, busy, done} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: addr=%h valid=%b data=%h busy=%b done=%b required all 0",
                     parallel_address, out_valid, out_data, busy, done);
        end
        exp_q.delete();
        out_ready = 1'b1;
        got0 = got;
        start_scan(24'h000060, 24'd3);
        wait_done(30, "reset_rescan");
        tests_run++;
        if (got - got0 != 3 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL reset_rescan: %0d bytes pending %0d required 3 and 0", got - got0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_abort();
        test_ignored_start();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
